// File: rtl/a2_narrowing_stage.sv
// 8-bit to 6-bit narrowing stage with a two-entry skid buffer and a saturating loss counter.
// Define A2_NARROW_SATURATE_EN to clamp lossy words to 6'h3F instead of truncating them.
module a2_narrowing_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [5:0]       out_data_o,
    output logic             out_lost_o,
    input  logic             clr_count_i,
    output logic [CNT_W-1:0] loss_count_o
);

    logic             main_vld_q, main_vld_d;
    logic [5:0]       main_data_q, main_data_d;
    logic             main_lost_q, main_lost_d;
    logic             skid_vld_q, skid_vld_d;
    logic [5:0]       skid_data_q, skid_data_d;
    logic             skid_lost_q, skid_lost_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       acc;
    logic       xfer;
    logic       new_lost;
    logic [5:0] new_data;

    assign acc  = in_valid_i & in_ready_q;
    assign xfer = main_vld_q & out_ready_i;

    // Gate the incoming word with acc so an undriven bus never reaches the registers.
    always_comb begin
        new_lost = 1'b0;
        new_data = 6'h00;
        if (acc) begin
            new_lost = |in_data_i[7:6];
`ifdef A2_NARROW_SATURATE_EN
            new_data = new_lost ? 6'h3F : in_data_i[5:0];
`else
            new_data = in_data_i[5:0];
`endif
        end
    end

    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        main_lost_d = main_lost_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_lost_d = skid_lost_q;

        if (!main_vld_q || xfer) begin
            if (skid_vld_q) begin
                main_vld_d  = 1'b1;
                main_data_d = skid_data_q;
                main_lost_d = skid_lost_q;
                skid_vld_d  = acc;
                if (acc) begin
                    skid_data_d = new_data;
                    skid_lost_d = new_lost;
                end
            end else begin
                main_vld_d = acc;
                if (acc) begin
                    main_data_d = new_data;
                    main_lost_d = new_lost;
                end
            end
        end else if (acc) begin
            skid_vld_d  = 1'b1;
            skid_data_d = new_data;
            skid_lost_d = new_lost;
        end

        in_ready_d = ~skid_vld_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_count_i) begin
            cnt_d = '0;
        end else if (acc && new_lost && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            main_vld_q  <= 1'b0;
            main_data_q <= 6'h00;
            main_lost_q <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= 6'h00;
            skid_lost_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            main_lost_q <= main_lost_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_lost_q <= skid_lost_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = main_vld_q;
    assign out_data_o   = main_data_q;
    assign out_lost_o   = main_lost_q;
    assign loss_count_o = cnt_q;

endmodule

// File: tb/tb_a2_narrowing_stage.sv
// Self-checking bench for a2_narrowing_stage: directed vector table, hand sequences, random traffic vs a queue model.
module tb_a2_narrowing_stage;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_data;
    logic             out_lost;
    logic             clr_count;
    logic [CNT_W-1:0] loss_count;

    int errors = 0;
    int checks = 0;

    a2_narrowing_stage #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_lost_o   (out_lost),
        .clr_count_i  (clr_count),
        .loss_count_o (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stored words in arrival order, plus counter and ready flag.
    logic [6:0] m_q[$];
    int         m_cnt;
    logic       m_rdy;

    function automatic logic [5:0] narrow(input logic [7:0] d);
`ifdef A2_NARROW_SATURATE_EN
        return (d[7:6] != 2'b00) ? 6'h3F : d[5:0];
`else
        return d[5:0];
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt = 0;
        m_rdy = 1'b1;
    endtask

    // Drive one cycle's inputs, advance the model across the edge, return at the next falling edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic ordy, input logic clr);
        logic acc;
        logic lost;
        in_valid  = v;
        in_data   = v ? d : 8'hxx;
        out_ready = ordy;
        clr_count = clr;
        acc  = v && m_rdy;
        lost = (d[7:6] != 2'b00);
        if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
        if (acc) m_q.push_back({narrow(d), lost});
        if (clr) m_cnt = 0;
        else if (acc && lost && m_cnt < CMAX) m_cnt++;
        m_rdy = (m_q.size() < 2);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string name);
        chk({name, ".out_valid"}, int'(out_valid), int'(m_q.size() > 0));
        chk({name, ".in_ready"}, int'(in_ready), int'(m_rdy));
        chk({name, ".loss_count"}, int'(loss_count), m_cnt);
        if (m_q.size() > 0) begin
            chk({name, ".out_data"}, int'(out_data), int'(m_q[0][6:1]));
            chk({name, ".out_lost"}, int'(out_lost), int'(m_q[0][0]));
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ordy;
        logic       clr;
        logic       e_valid;
        logic [5:0] e_data;
        logic       e_lost;
        logic       e_rdy;
        int         e_cnt;
    } vec_t;

    vec_t vecs[9];
    logic [5:0] db6;

    initial begin
`ifdef A2_NARROW_SATURATE_EN
        db6 = 6'h3F;
`else
        db6 = 6'h1B;
`endif
        //          v     d      ordy  clr   valid data   lost  rdy   cnt
        vecs[0] = '{1'b1, 8'h32, 1'b1, 1'b0, 1'b1, 6'h32, 1'b0, 1'b1, 0};
        vecs[1] = '{1'b1, 8'hDB, 1'b1, 1'b0, 1'b1, db6,   1'b1, 1'b1, 1};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1};
        vecs[3] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 6'h01, 1'b0, 1'b1, 1};
        vecs[4] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 6'h01, 1'b0, 1'b0, 1};
        vecs[5] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 6'h01, 1'b0, 1'b0, 1};
        vecs[6] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 6'h02, 1'b0, 1'b1, 1};
        vecs[7] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 6'h03, 1'b0, 1'b1, 1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        clr_count = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.out_data", int'(out_data), 0);
        chk("rst.out_lost", int'(out_lost), 0);
        chk("rst.in_ready", int'(in_ready), 1);
        chk("rst.loss_count", int'(loss_count), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].ordy, vecs[i].clr);
            chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(vecs[i].e_valid));
            chk($sformatf("vec%0d.in_ready", i), int'(in_ready), int'(vecs[i].e_rdy));
            chk($sformatf("vec%0d.loss_count", i), int'(loss_count), vecs[i].e_cnt);
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d.out_data", i), int'(out_data), int'(vecs[i].e_data));
                chk($sformatf("vec%0d.out_lost", i), int'(out_lost), int'(vecs[i].e_lost));
            end
        end

        // Counter saturation: 256 more lossy words on top of the one already counted.
        for (int i = 0; i < 256; i++) cycle(1'b1, 8'h80 | 8'(i & 8'h3F), 1'b1, 1'b0);
        chk("sat.loss_count", int'(loss_count), CMAX);
        check_model("sat");
        cycle(1'b1, 8'hC5, 1'b1, 1'b1);
        chk("clr_wins.loss_count", int'(loss_count), 0);
        check_model("clr_wins");

        // Fill both entries with lossy words, then reset between edges.
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        cycle(1'b1, 8'h82, 1'b0, 1'b0);
        check_model("full");
        #2 reset = 1'b1;
        #1;
        chk("midrst.out_valid", int'(out_valid), 0);
        chk("midrst.in_ready", int'(in_ready), 1);
        chk("midrst.loss_count", int'(loss_count), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            chk("postrst.out_valid", int'(out_valid), 0);
        end
        cycle(1'b1, 8'h15, 1'b1, 1'b0);
        check_model("postrst.first");

        for (int i = 0; i < 3000; i++) begin
            logic       v;
            logic       ordy;
            logic       clr;
            logic [7:0] d;
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 63) == 0);
            d    = 8'($urandom);
            cycle(v, d, ordy, clr);
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/a2_narrowing_stage.md
# a2_narrowing_stage

Pipelined 8-bit to 6-bit narrowing stage for the writeback/immediate path. It does the reverse of zero extension: it accepts 8-bit datapath values over a valid/ready handshake and emits 6-bit fields. It flags any value whose upper two bits are non-zero and counts such losses. A two-entry skid buffer gives a registered `in_ready` while keeping full throughput, and it sits between the ALU result register and the 6-bit field consumers.

## Interface
- `CNT_W`, default 8: width of the loss counter.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: stage can accept a word. Registered.
- `in_data` input 8: unnarrowed value.
- `out_valid` output 1: output word valid.
- `out_ready` input 1: downstream accepts the word.
- `out_data` output 6: narrowed value.
- `out_lost` output 1: 1 when `in_data[7:6]` for this word was non-zero.
- `clr_count` input 1: synchronous clear of `loss_count`.
- `loss_count` output CNT_W: saturating count of accepted lossy words.

## Operation
- Accept condition: `acc = in_valid & in_ready`. Transfer condition: `xfer = out_valid & out_ready`.
- Narrowing of one word: `lost = |in_data[7:6]`. Without the macro, `data6 = in_data[5:0]`.
- Storage holds two entries, each a `{data6, lost}` pair:
  - Main register, which drives `out_*`.
  - Skid register.
- Each cycle, in priority order:
  1. Main empty or `xfer`, skid full: main takes the skid contents and the skid empties. If `acc` is also true, the new word goes into the skid.
  2. Main empty or `xfer`, skid empty: main takes the new word if `acc`, otherwise main becomes empty.
  3. Main full and no `xfer`: if `acc`, the new word goes into the skid.
- `in_ready` (next cycle) = skid empty after this cycle's update.
- Words leave in strict arrival order. None are lost or duplicated.
- `out_valid` = main full. While `out_valid=1` and `out_ready=0`, `out_data` and `out_lost` must hold stable.
- `loss_count`:
  - Increments on `acc & lost`.
  - Saturates at 2^CNT_W−1.
  - `clr_count` sets it to 0 and wins over a simultaneous increment.

## Timing
- Reset values (asynchronous):
  - `out_valid=0`, `out_data=0`, `out_lost=0`.
  - Skid empty, `in_ready=1`, `loss_count=0`.
- Latency is 1 cycle: a word accepted at edge N is presented on `out_*` after edge N when main was empty or draining.
- Throughput: 1 word/cycle while `out_ready=1`.
- Backpressure:
  - With `out_ready=0`, the stage absorbs at most two words.
  - `in_ready` falls in the cycle after the skid fills.
  - `in_ready` rises in the cycle after the skid drains into main.
- Simultaneous `acc` and `xfer` with the skid empty: main is replaced. Occupancy is unchanged and `in_ready` stays 1.
- Reset asserted mid-operation:
  - Both entries are discarded immediately.
  - Outputs return to reset values without waiting for `clk`.
  - The first accept after deassertion is the first edge with `in_valid=1`.
- `in_data` is ignored whenever `acc=0`. X on `in_data` in that case must not propagate.

## Configuration
- `A2_NARROW_SATURATE_EN`
  - Defined: a lossy word produces `data6 = 6'h3F` (saturation). Non-lossy words pass `in_data[5:0]`.
  - Undefined: plain truncation, `data6 = in_data[5:0]` always.
- `out_lost` and `loss_count` behave identically in both builds.

## Test plan
- Basic word: after reset, `in_data=8'h32` with `out_ready=1` → next cycle `out_data=6'h32`, `out_lost=0`, `loss_count=0`.
- Lossy word: `in_data=8'hDB` → `out_lost=1` and `loss_count=1`.
  - `out_data=6'h1B` without the macro.
  - `out_data=6'h3F` with `A2_NARROW_SATURATE_EN`.
- Backpressure: hold `out_ready=0` and stream `8'h01`, `8'h02`, `8'h03`.
  - `in_ready` falls after the second accept, so `8'h03` is not accepted.
  - Then set `out_ready=1` → outputs `6'h01`, `6'h02`, `6'h03` in order with no gaps, and `in_ready` returns to 1.
- Counter limits: feed 256 lossy words (CNT_W=8) → `loss_count` holds at 255.
  - Then assert `clr_count` together with a lossy accept → `loss_count=0`.
- Reset mid-stream: with both entries full, assert `reset` between clock edges.
  - Required immediately: `out_valid=0`, `in_ready=1`, `loss_count=0`.
  - After deassertion, no stale words appear on the output.
